// File: rtl/mips32_pkg.sv
// Shared definitions for the pipelined MIPS32-subset core: opcodes, instruction
// classes, pipeline register layouts and instruction field helpers.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} itype_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    itype_e      typ;
    alu_op_e     op;
    logic        we;
    logic        bnez;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } id_ex_t;

  typedef struct packed {
    itype_e      typ;
    logic        we;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] sd;
  } ex_mem_t;

  typedef struct packed {
    itype_e      typ;
    logic        we;
    logic [4:0]  dst;
    logic [31:0] val;
  } mem_wb_t;

  function automatic logic [5:0]  f_opc(input logic [31:0] ir); return ir[31:26]; endfunction
  function automatic logic [4:0]  f_rs (input logic [31:0] ir); return ir[25:21]; endfunction
  function automatic logic [4:0]  f_rt (input logic [31:0] ir); return ir[20:16]; endfunction
  function automatic logic [4:0]  f_rd (input logic [31:0] ir); return ir[15:11]; endfunction
  function automatic logic [31:0] f_imm(input logic [31:0] ir); return {{16{ir[15]}}, ir[15:0]}; endfunction

  function automatic itype_e f_type(input logic [5:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

  // Loads/stores/branches fall through to ADD for address arithmetic.
  function automatic alu_op_e f_aluop(input logic [5:0] opc);
    case (opc)
      OP_SUB, OP_SUBI: return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_SLT, OP_SLTI: return ALU_SLT;
      OP_MUL:          return ALU_MUL;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational integer ALU; all results wrap modulo 2^32.
module mips32_alu
  import mips32_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = a + b;
    case (op)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      ALU_MUL: result = a * b;
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage MIPS32-subset core with unified word memory, EX-stage branch
// resolution, full operand forwarding and a freeze once HLT retires.
module pipe_mips32
  import mips32_pkg::*;
(
  input logic clk,
  input logic rst_n
);

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:1023];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  if_id_t  if_id;
  id_ex_t  id_ex,  id_dec;
  ex_mem_t ex_mem, ex_nxt;
  mem_wb_t mem_wb, mem_nxt;
  itype_e  id_typ;
  logic [31:0] fa, fb, alu_b, alu_y, target;
  logic        taken, stop_fetch;

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b = '0;
    return b;
  endfunction

  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b     = '0;
    b.typ = NOP;
    return b;
  endfunction

  // Register read with write-through from the instruction retiring this cycle.
  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 5'd0) return '0;
    if (mem_wb.we && mem_wb.dst == r) return mem_wb.val;
    return Reg[r];
  endfunction

  // Loads in EX/MEM only hold an address, so they never forward from there.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (ex_mem.we && ex_mem.typ != LOAD && ex_mem.dst == r) return ex_mem.alu;
    if (mem_wb.we && mem_wb.dst == r) return mem_wb.val;
    return v;
  endfunction

  // ID
  always_comb begin
    id_typ      = if_id.vld ? f_type(f_opc(if_id.ir)) : NOP;
    id_dec      = id_ex_bubble();
    id_dec.typ  = id_typ;
    id_dec.op   = f_aluop(f_opc(if_id.ir));
    id_dec.bnez = (f_opc(if_id.ir) == OP_BNEQZ);
    id_dec.rs   = f_rs(if_id.ir);
    id_dec.rt   = f_rt(if_id.ir);
    id_dec.a    = rf_read(f_rs(if_id.ir));
    id_dec.b    = rf_read(f_rt(if_id.ir));
    id_dec.imm  = f_imm(if_id.ir);
    id_dec.npc  = if_id.npc;
    case (id_typ)
      RR_ALU:       id_dec.dst = f_rd(if_id.ir);
      RM_ALU, LOAD: id_dec.dst = f_rt(if_id.ir);
      default:      id_dec.dst = 5'd0;
    endcase
    // R0 destinations never raise a write enable, so forwarding ignores them too.
    id_dec.we  = (id_typ == RR_ALU || id_typ == RM_ALU || id_typ == LOAD) && (id_dec.dst != 5'd0);
    stop_fetch = (id_typ == HALT) || (id_ex.typ == HALT) || (ex_mem.typ == HALT) || (mem_wb.typ == HALT);
  end

  // EX
  always_comb begin
    fa     = fwd(id_ex.rs, id_ex.a);
    fb     = fwd(id_ex.rt, id_ex.b);
    alu_b  = (id_ex.typ == RR_ALU) ? fb : id_ex.imm;
    target = id_ex.npc + id_ex.imm;
    taken  = (id_ex.typ == BRANCH) && (id_ex.bnez ? (fa != 32'd0) : (fa == 32'd0));
    TAKEN_BRANCH = taken && !HALTED;
    ex_nxt     = '0;
    ex_nxt.typ = id_ex.typ;
    ex_nxt.we  = id_ex.we;
    ex_nxt.dst = id_ex.dst;
    ex_nxt.alu = alu_y;
    ex_nxt.sd  = fb;
  end

  mips32_alu u_alu (
    .op     (id_ex.op),
    .a      (fa),
    .b      (alu_b),
    .result (alu_y)
  );

  // MEM
  always_comb begin
    mem_nxt     = '0;
    mem_nxt.typ = ex_mem.typ;
    mem_nxt.we  = ex_mem.we;
    mem_nxt.dst = ex_mem.dst;
    mem_nxt.val = (ex_mem.typ == LOAD) ? Mem[ex_mem.alu[9:0]] : ex_mem.alu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC     <= '0;
      HALTED <= 1'b0;
      if_id  <= if_id_bubble();
      id_ex  <= id_ex_bubble();
      ex_mem <= '{typ: NOP, we: 1'b0, dst: 5'd0, alu: 32'd0, sd: 32'd0};
      mem_wb <= '{typ: NOP, we: 1'b0, dst: 5'd0, val: 32'd0};
    end else if (!HALTED) begin
      ex_mem <= ex_nxt;
      mem_wb <= mem_nxt;
      if (mem_wb.typ == HALT) HALTED <= 1'b1;
      if (taken) begin
        PC    <= target;
        if_id <= if_id_bubble();
        id_ex <= id_ex_bubble();
      end else begin
        id_ex <= id_dec;
        if (stop_fetch) begin
          if_id <= if_id_bubble();
        end else begin
          if_id <= '{vld: 1'b1, ir: Mem[PC[9:0]], npc: PC + 32'd1};
          PC    <= PC + 32'd1;
        end
      end
    end
  end

  // Architectural state is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && !HALTED) begin
      if (mem_wb.we) Reg[mem_wb.dst] <= mem_wb.val;
      if (ex_mem.typ == STORE) Mem[ex_mem.alu[9:0]] <= ex_mem.sd;
    end
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed and random-program bench for pipe_mips32 against an
// instruction-at-a-time architectural model.
module tb_pipe_mips32;
  import mips32_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  int ntaken = 0;
  int mtaken;

  logic [31:0] prog [$];
  logic [31:0] mr [32];
  logic [31:0] mm [1024];
  logic [31:0] mpc;

  pipe_mips32 dut (.clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;
  always @(negedge clk) if (dut.TAKEN_BRANCH === 1'b1) ntaken++;

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs, rt, rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input bit rnd);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      mm[i] = (i < prog.size()) ? prog[i] : 32'h0;
      dut.Mem[i] = mm[i];
    end
    for (int k = 0; k < 32; k++) begin
      if (!rnd || k == 0) mr[k] = 32'(k);
      else mr[k] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      dut.Reg[k] = mr[k];
    end
  endtask

  task automatic set_mem(input int a, input logic [31:0] v);
    mm[a] = v;
    dut.Mem[a] = v;
  endtask

  task automatic go();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int c;
    c = 0;
    while (dut.HALTED !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_halted"}, {31'b0, dut.HALTED}, 32'd1);
  endtask

  // Sequential ISA interpreter: one instruction per step, no pipeline notion.
  task automatic model_run();
    logic [31:0] ir, a, b, imm, ad, pc;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    pc = 0;
    mtaken = 0;
    for (int s = 0; s < 2000; s++) begin
      ir = mm[pc[9:0]];
      op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      imm = {{16{ir[15]}}, ir[15:0]};
      a = mr[rs]; b = mr[rt]; ad = a + imm;
      pc = pc + 1;
      case (op)
        6'h00: mr[rd] = a + b;
        6'h01: mr[rd] = a - b;
        6'h02: mr[rd] = a & b;
        6'h03: mr[rd] = a | b;
        6'h04: mr[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h05: mr[rd] = a * b;
        6'h0a: mr[rt] = a + imm;
        6'h0b: mr[rt] = a - imm;
        6'h0c: mr[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        6'h08: mr[rt] = mm[ad[9:0]];
        6'h09: mm[ad[9:0]] = b;
        6'h0d: if (a != 0) begin pc = pc + imm; mtaken++; end
        6'h0e: if (a == 0) begin pc = pc + imm; mtaken++; end
        6'h3f: break;
        default: ;
      endcase
      mr[0] = 32'h0;
    end
    mpc = pc;
  endtask

  task automatic gen_random();
    int len, k, p, off;
    len = 20 + $urandom_range(0, 10);
    prog.delete();
    while (prog.size() < len) begin
      k = $urandom_range(0, 9);
      p = prog.size();
      if (k <= 4)
        prog.push_back(r_ins(6'($urandom_range(0, 5)), 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))));
      else if (k <= 6)
        prog.push_back(i_ins(6'(10 + $urandom_range(0, 2)), 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 16'($urandom)));
      else if (k == 7) begin
        prog.push_back(i_ins(OP_LW, 5'd0, 5'($urandom_range(0, 7)), 16'(512 + $urandom_range(0, 15))));
        prog.push_back(32'h4000_0000);
      end else if (k == 8)
        prog.push_back(i_ins(OP_SW, 5'd0, 5'($urandom_range(0, 7)), 16'(512 + $urandom_range(0, 15))));
      else begin
        off = $urandom_range(0, 3);
        if (p + 1 + off > len) off = len - (p + 1);
        prog.push_back(i_ins($urandom_range(0, 1) ? OP_BEQZ : OP_BNEQZ,
                             5'($urandom_range(0, 7)), 5'd0, 16'(off)));
      end
    end
    prog.push_back(32'hfc00_0000);
  endtask

  initial begin
    int t0;
    @(negedge clk);
    chk("rst_pc", dut.PC, 32'd0);
    chk("rst_halted", {31'b0, dut.HALTED}, 32'd0);
    chk("rst_taken", {31'b0, dut.TAKEN_BRANCH}, 32'd0);

    // Dependent adds with fillers; halts well inside 20 cycles.
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h2801000a, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    load(0); go();
    run_to_halt("t1", 20);
    chk("t1_r1", dut.Reg[1], 32'd10);
    chk("t1_r2", dut.Reg[2], 32'd20);
    chk("t1_r3", dut.Reg[3], 32'd25);
    chk("t1_r4", dut.Reg[4], 32'd30);
    chk("t1_r5", dut.Reg[5], 32'd55);
    chk("t1_pc", dut.PC, 32'd9);

    // Load, forwarded add, store.
    prog = '{i_ins(OP_ADDI, 0, 1, 120), i_ins(OP_LW, 1, 2, 0), r_ins(OP_OR, 3, 3, 3),
             i_ins(OP_ADDI, 2, 2, 45), i_ins(OP_SW, 1, 2, 1), 32'hfc000000};
    load(0); set_mem(120, 32'd85); go();
    run_to_halt("t2", 30);
    chk("t2_mem121", dut.Mem[121], 32'd130);
    chk("t2_r2", dut.Reg[2], 32'd130);

    // BEQZ taken skips both writes; BNEQZ falls through.
    for (int v = 0; v < 2; v++) begin
      prog = '{i_ins(OP_ADDI, 0, 1, 0), i_ins(v == 0 ? OP_BEQZ : OP_BNEQZ, 1, 0, 2),
               i_ins(OP_ADDI, 0, 6, 1), i_ins(OP_ADDI, 0, 6, 1), 32'hfc000000};
      load(0); go();
      t0 = ntaken;
      run_to_halt($sformatf("t3_%0d", v), 30);
      chk($sformatf("t3_%0d_r6", v), dut.Reg[6], v == 0 ? 32'd6 : 32'd1);
      chk($sformatf("t3_%0d_pulses", v), 32'(ntaken - t0), v == 0 ? 32'd1 : 32'd0);
    end

    // R0 stays zero and forwards as zero.
    prog = '{i_ins(OP_ADDI, 0, 0, 5), r_ins(OP_ADD, 0, 0, 8), 32'hfc000000};
    load(0); go();
    run_to_halt("t4", 30);
    chk("t4_r0", dut.Reg[0], 32'd0);
    chk("t4_r8", dut.Reg[8], 32'd0);

    // Mid-run reset: only instr 0 has retired after five fetch edges.
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h2801000a, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    load(0); go();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_pc", dut.PC, 32'd0);
    chk("t5_halted", {31'b0, dut.HALTED}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_r1", dut.Reg[1], 32'd10);
    chk("t5_r2", dut.Reg[2], 32'd2);
    chk("t5_r3", dut.Reg[3], 32'd3);
    chk("t5_r4", dut.Reg[4], 32'd4);
    rst_n = 1'b1;
    run_to_halt("t5", 30);
    chk("t5_r4_end", dut.Reg[4], 32'd30);
    chk("t5_r5_end", dut.Reg[5], 32'd55);

    // Store behind HLT never executes; everything stays frozen.
    prog = '{i_ins(OP_ADDI, 0, 1, 77), 32'hfc000000, i_ins(OP_SW, 0, 1, 600)};
    load(0); go();
    run_to_halt("t6", 30);
    chk("t6_pc", dut.PC, 32'd2);
    repeat (10) @(negedge clk);
    chk("t6_pc_hold", dut.PC, 32'd2);
    chk("t6_mem600", dut.Mem[600], 32'd0);
    chk("t6_r1", dut.Reg[1], 32'd77);

    // Random forward-branching programs against the ISA model.
    for (int t = 0; t < 12; t++) begin
      gen_random();
      load(1);
      for (int i = 512; i < 528; i++) set_mem(i, $urandom);
      model_run();
      go();
      t0 = ntaken;
      run_to_halt($sformatf("rnd%0d", t), 300);
      for (int k = 0; k < 32; k++) chk($sformatf("rnd%0d_r%0d", t, k), dut.Reg[k], mr[k]);
      for (int i = 512; i < 528; i++) chk($sformatf("rnd%0d_m%0d", t, i), dut.Mem[i], mm[i]);
      chk($sformatf("rnd%0d_pc", t), dut.PC, mpc);
      chk($sformatf("rnd%0d_taken", t), 32'(ntaken - t0), 32'(mtaken));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
